// File: rtl/byte_gather64_if.sv
// ---------------------------------------------------------------------------
// byte_gather64_if
// Stream bundle for the byte-serial to 64-bit word assembler.
//   in_*  : byte input stream (data, valid, last, ready)
//   out_* : word output stream (data, nbytes, last, valid, ready)
//   out_timeout : present only when BYTE_GATHER_TIMEOUT_EN is defined
// Modports:
//   slave  : the assembler's view (consumes bytes, produces words)
//   master : the environment's view (produces bytes, consumes words)
// ---------------------------------------------------------------------------
interface byte_gather64_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [63:0] out_data;
  logic [3:0]  out_nbytes;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
`ifdef BYTE_GATHER_TIMEOUT_EN
  logic        out_timeout;
`endif

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_nbytes, out_last, out_valid
`ifdef BYTE_GATHER_TIMEOUT_EN
    , output out_timeout
`endif
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_nbytes, out_last, out_valid
`ifdef BYTE_GATHER_TIMEOUT_EN
    , input out_timeout
`endif
  );
endinterface

// File: rtl/byte_gather64.sv
// ---------------------------------------------------------------------------
// byte_gather64
// Byte-serial to 64-bit word assembler. Byte k of a word lands in
// out_data[8k+7:8k] (byte 0 in the LSBs). Words close after 8 bytes or on
// in_last; partial words are zero-padded above the last valid lane.
// Double-buffered (assembly register + output register) so one byte per
// cycle is sustained while the consumer keeps out_ready high.
//
// Optional feature macro: BYTE_GATHER_TIMEOUT_EN
//   When defined, a partial word that sits idle for TIMEOUT_CYCLES cycles is
//   flushed with out_timeout=1, and the TIMEOUT_CYCLES parameter exists.
//
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : byte_gather64_if.slave
//         in_data/in_valid/in_last -> in_ready  (byte stream in)
//         out_data/out_nbytes/out_last/out_valid <- out_ready (word stream out)
//         out_timeout (only with BYTE_GATHER_TIMEOUT_EN)
// ---------------------------------------------------------------------------
module byte_gather64
`ifdef BYTE_GATHER_TIMEOUT_EN
  #(parameter int TIMEOUT_CYCLES = 255)
`endif
(
  input logic            clk,
  input logic            rst,
  byte_gather64_if.slave bus
);

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_FULL    = 1'b1
  } state_e;

  // Replace lane idx of the assembly word with a new byte.
  function automatic logic [63:0] merge_lane(input logic [63:0] acc,
                                             input logic [2:0]  idx,
                                             input logic [7:0]  data);
    logic [63:0] tmp;
    tmp = acc;
    tmp[{idx, 3'b000} +: 8] = data;
    return tmp;
  endfunction

  // State and datapath registers
  state_e      state_q,       state_d;
  logic [63:0] acc_q,         acc_d;
  logic [2:0]  idx_q,         idx_d;
  logic [3:0]  hold_nbytes_q, hold_nbytes_d;
  logic        hold_last_q,   hold_last_d;
  logic [63:0] out_data_q,    out_data_d;
  logic [3:0]  out_nbytes_q,  out_nbytes_d;
  logic        out_last_q,    out_last_d;
  logic        out_valid_q,   out_valid_d;
`ifdef BYTE_GATHER_TIMEOUT_EN
  logic        hold_timeout_q, hold_timeout_d;
  logic        out_timeout_q,  out_timeout_d;
  logic [15:0] idle_cnt_q,     idle_cnt_d;
`endif

  // Combinational helpers
  logic        in_ready_s;
  logic        hs_s;
  logic        out_free_s;
  logic [63:0] merged_s;
  logic        close_byte_s;
  logic        tmo_fire_s;
  logic        close_s;
  logic [63:0] word_data_s;
  logic [3:0]  word_nbytes_s;
  logic        word_last_s;
`ifdef BYTE_GATHER_TIMEOUT_EN
  logic        word_timeout_s;
`endif

  assign in_ready_s   = (state_q == ST_COLLECT);
  assign hs_s         = bus.in_valid & in_ready_s;
  assign out_free_s   = ~out_valid_q | bus.out_ready;
  // Lanes above idx are already zero in acc, so the merge yields the padded word.
  assign merged_s     = merge_lane(acc_q, idx_q, bus.in_data);
  assign close_byte_s = hs_s & ((idx_q == 3'd7) | bus.in_last);

`ifdef BYTE_GATHER_TIMEOUT_EN
  // A handshake in the timeout cycle suppresses the flush (the byte wins).
  assign tmo_fire_s = in_ready_s & (idx_q != 3'd0) & ~hs_s &
                      (idle_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_fire_s = 1'b0;
`endif

  assign close_s = close_byte_s | tmo_fire_s;

  // Select the contents of the word being closed this cycle (byte or timeout).
  always_comb begin
    word_data_s    = merged_s;
    word_nbytes_s  = {1'b0, idx_q} + 4'd1;
    word_last_s    = bus.in_last;
`ifdef BYTE_GATHER_TIMEOUT_EN
    word_timeout_s = 1'b0;
    if (tmo_fire_s) begin
      word_data_s    = acc_q;
      word_nbytes_s  = {1'b0, idx_q};
      word_last_s    = 1'b0;
      word_timeout_s = 1'b1;
    end else begin
      word_timeout_s = 1'b0;
    end
`endif
  end

  // Next-state logic for the assembly FSM and the output register.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    idx_d         = idx_q;
    hold_nbytes_d = hold_nbytes_q;
    hold_last_d   = hold_last_q;
    out_data_d    = out_data_q;
    out_nbytes_d  = out_nbytes_q;
    out_last_d    = out_last_q;
    out_valid_d   = out_valid_q;
`ifdef BYTE_GATHER_TIMEOUT_EN
    hold_timeout_d = hold_timeout_q;
    out_timeout_d  = out_timeout_q;
`endif

    // A completed output handshake empties the register unless reloaded below.
    if (out_valid_q & bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    case (state_q)
      ST_COLLECT: begin
        if (close_s) begin
          if (out_free_s) begin
            out_data_d   = word_data_s;
            out_nbytes_d = word_nbytes_s;
            out_last_d   = word_last_s;
            out_valid_d  = 1'b1;
`ifdef BYTE_GATHER_TIMEOUT_EN
            out_timeout_d = word_timeout_s;
`endif
            acc_d = 64'd0;
            idx_d = 3'd0;
          end else begin
            // Park the finished word in acc until the output register drains.
            acc_d         = word_data_s;
            hold_nbytes_d = word_nbytes_s;
            hold_last_d   = word_last_s;
`ifdef BYTE_GATHER_TIMEOUT_EN
            hold_timeout_d = word_timeout_s;
`endif
            state_d = ST_FULL;
          end
        end else if (hs_s) begin
          acc_d = merged_s;
          idx_d = idx_q + 3'd1;
        end else begin
          acc_d = acc_q;
          idx_d = idx_q;
        end
      end
      ST_FULL: begin
        // out_ready high means the register is free this edge; move the held word.
        if (bus.out_ready) begin
          out_data_d   = acc_q;
          out_nbytes_d = hold_nbytes_q;
          out_last_d   = hold_last_q;
          out_valid_d  = 1'b1;
`ifdef BYTE_GATHER_TIMEOUT_EN
          out_timeout_d = hold_timeout_q;
`endif
          acc_d   = 64'd0;
          idx_d   = 3'd0;
          state_d = ST_COLLECT;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_COLLECT;
        acc_d   = 64'd0;
        idx_d   = 3'd0;
      end
    endcase
  end

`ifdef BYTE_GATHER_TIMEOUT_EN
  // Idle counter: clears on bytes and on flush, runs only on a pending partial word.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (hs_s) begin
      idle_cnt_d = 16'd0;
    end else if (tmo_fire_s) begin
      idle_cnt_d = 16'd0;
    end else if (in_ready_s && (idx_q != 3'd0)) begin
      idle_cnt_d = idle_cnt_q + 16'd1;
    end else begin
      idle_cnt_d = idle_cnt_q;
    end
  end
`endif

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_COLLECT;
      acc_q         <= 64'd0;
      idx_q         <= 3'd0;
      hold_nbytes_q <= 4'd0;
      hold_last_q   <= 1'b0;
      out_data_q    <= 64'd0;
      out_nbytes_q  <= 4'd0;
      out_last_q    <= 1'b0;
      out_valid_q   <= 1'b0;
`ifdef BYTE_GATHER_TIMEOUT_EN
      hold_timeout_q <= 1'b0;
      out_timeout_q  <= 1'b0;
      idle_cnt_q     <= 16'd0;
`endif
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      idx_q         <= idx_d;
      hold_nbytes_q <= hold_nbytes_d;
      hold_last_q   <= hold_last_d;
      out_data_q    <= out_data_d;
      out_nbytes_q  <= out_nbytes_d;
      out_last_q    <= out_last_d;
      out_valid_q   <= out_valid_d;
`ifdef BYTE_GATHER_TIMEOUT_EN
      hold_timeout_q <= hold_timeout_d;
      out_timeout_q  <= out_timeout_d;
      idle_cnt_q     <= idle_cnt_d;
`endif
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_data   = out_data_q;
  assign bus.out_nbytes = out_nbytes_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_valid  = out_valid_q;
`ifdef BYTE_GATHER_TIMEOUT_EN
  assign bus.out_timeout = out_timeout_q;
`endif

endmodule
